// File: rtl/full_xor_nk.sv
// full_xor_nk: layered pairwise refresh of N Boolean shares, then a two-stage
// elastic pipeline producing refreshed shares and (in unmask mode) their XOR.
`default_nettype none

package full_xor_nk_pkg;

   function automatic int pair_count(input int n);
      int cnt;
      cnt = 0;
      for (int l = 0; (1 << l) < n; l++) begin
         for (int i = 0; i < n; i++) begin
            if ((((i >> l) % 2) == 0) && ((i + (1 << l)) < n)) begin
               cnt++;
            end
         end
      end
      return cnt;
   endfunction

endpackage

module full_xor_nk
   import full_xor_nk_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 4,
   localparam int MASKWIDTH = K_WIDTH * N_SHARES,
   localparam int RANDNUM   = pair_count(N_SHARES)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic                         i_vld,
   output logic                         o_rdy,
   input  logic                         i_mode,
   input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
   input  logic [MASKWIDTH-1:0]         i_x,
   output logic [MASKWIDTH-1:0]         o_x,
   output logic [K_WIDTH-1:0]           o_z,
   output logic                         o_mode,
   output logic                         o_vld,
   input  logic                         i_rdy
);

   localparam int LAYERS = $clog2(N_SHARES);

   logic [MASKWIDTH-1:0] ref_x;
   logic [MASKWIDTH-1:0] s1_x;
   logic                 s1_mode;
   logic                 s1_vld;
   logic [K_WIDTH-1:0]   s1_xor;
   logic                 adv1;
   logic                 adv2;
   logic                 accept;

   // Pairs within a layer are disjoint, so in-place updates never collide.
   always_comb begin
      int p;
      p     = 0;
      ref_x = i_x;
      for (int l = 0; l < LAYERS; l++) begin
         for (int i = 0; i < N_SHARES; i++) begin
            if ((((i >> l) % 2) == 0) && ((i + (1 << l)) < N_SHARES)) begin
               ref_x[i*K_WIDTH +: K_WIDTH] =
                  ref_x[i*K_WIDTH +: K_WIDTH] ^ rnd[p*K_WIDTH +: K_WIDTH];
               ref_x[(i + (1 << l))*K_WIDTH +: K_WIDTH] =
                  ref_x[(i + (1 << l))*K_WIDTH +: K_WIDTH] ^ rnd[p*K_WIDTH +: K_WIDTH];
               p++;
            end
         end
      end
   end

   always_comb begin
      s1_xor = '0;
      for (int s = 0; s < N_SHARES; s++) begin
         s1_xor = s1_xor ^ s1_x[s*K_WIDTH +: K_WIDTH];
      end
   end

   assign adv2   = ~o_vld | i_rdy;
   assign adv1   = ~s1_vld | adv2;
   assign o_rdy  = ena & rst_n & adv1;
   assign accept = i_vld & o_rdy;

   // Data registers load only alongside a valid bit being set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_mode <= 1'b0;
         s1_x    <= '0;
         o_vld   <= 1'b0;
         o_mode  <= 1'b0;
         o_x     <= '0;
         o_z     <= '0;
      end else if (ena) begin
         if (adv1) begin
            s1_vld <= accept;
            if (accept) begin
               s1_x    <= ref_x;
               s1_mode <= i_mode;
            end
         end
         if (adv2) begin
            o_vld <= s1_vld;
            if (s1_vld) begin
               o_x    <= s1_x;
               o_z    <= s1_mode ? {K_WIDTH{1'b0}} : s1_xor;
               o_mode <= s1_mode;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_full_xor_nk.sv
// tb_full_xor_nk: randomized and directed checks of full_xor_nk against a
// queue-based model (N=4), plus unmask/refresh sweeps at N=3 and N=5.
`default_nettype none

module tb_full_xor_nk;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        ena, i_vld, i_mode, i_rdy;
   logic [31:0] i_x, rnd;
   logic        o_rdy, o_mode, o_vld;
   logic [31:0] o_x;
   logic [7:0]  o_z;

   logic        v3, m3, rdy3, vld3, mode3;
   logic [23:0] x3, ox3;
   logic [15:0] r3;
   logic [7:0]  oz3;

   logic        v5, m5, rdy5, vld5, mode5;
   logic [39:0] x5, r5, ox5;
   logic [7:0]  oz5;

   full_xor_nk #(.K_WIDTH(8), .N_SHARES(4)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .i_vld(i_vld), .o_rdy(o_rdy),
      .i_mode(i_mode), .rnd(rnd), .i_x(i_x), .o_x(o_x), .o_z(o_z),
      .o_mode(o_mode), .o_vld(o_vld), .i_rdy(i_rdy));

   full_xor_nk #(.K_WIDTH(8), .N_SHARES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .ena(1'b1), .i_vld(v3), .o_rdy(rdy3),
      .i_mode(m3), .rnd(r3), .i_x(x3), .o_x(ox3), .o_z(oz3),
      .o_mode(mode3), .o_vld(vld3), .i_rdy(1'b1));

   full_xor_nk #(.K_WIDTH(8), .N_SHARES(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .ena(1'b1), .i_vld(v5), .o_rdy(rdy5),
      .i_mode(m5), .rnd(r5), .i_x(x5), .o_x(ox5), .o_z(oz5),
      .o_mode(mode5), .o_vld(vld5), .i_rdy(1'b1));

   typedef struct {
      logic [31:0] x;
      logic [7:0]  z;
      logic        mode;
      int          age;
   } beat_t;

   beat_t q[$];
   int    checks = 0;
   int    errors = 0;

   logic        obs_vld, obs_rdy, obs_mode;
   logic [31:0] obs_x;
   logic [7:0]  obs_z;
   logic        exp_vld, exp_rdy, exp_mode;
   logic [31:0] exp_x;
   logic [7:0]  exp_z;
   logic        acc, xfer;

   // Every pair touching a share contributes its rnd word to that share.
   function automatic logic [127:0] refresh_ref(input int n, input logic [127:0] x,
                                                input logic [255:0] r);
      int pa[$];
      int pb[$];
      logic [127:0] y;
      for (int l = 0; (1 << l) < n; l++)
         for (int i = 0; i < n; i++)
            if ((((i >> l) % 2) == 0) && ((i + (1 << l)) < n)) begin
               pa.push_back(i);
               pb.push_back(i + (1 << l));
            end
      y = x;
      for (int s = 0; s < n; s++)
         foreach (pa[p])
            if (pa[p] == s || pb[p] == s) y[s*8 +: 8] = y[s*8 +: 8] ^ r[p*8 +: 8];
      return y;
   endfunction

   function automatic logic [7:0] xor_shares(input int n, input logic [127:0] x);
      logic [7:0] z;
      z = 8'h00;
      for (int s = 0; s < n; s++) z = z ^ x[s*8 +: 8];
      return z;
   endfunction

   function automatic beat_t make_beat(input logic m, input logic [31:0] x, input logic [31:0] r);
      beat_t b;
      logic [127:0] y;
      y      = refresh_ref(4, {96'd0, x}, {224'd0, r});
      b.x    = y[31:0];
      b.z    = m ? 8'h00 : xor_shares(4, {96'd0, x});
      b.mode = m;
      b.age  = 1;
      return b;
   endfunction

   // Drives one cycle from a falling edge, snapshots DUT and model views, then
   // advances the model across the rising edge.
   task automatic step(input logic e, input logic v, input logic m,
                       input logic [31:0] x, input logic [31:0] r, input logic rdy);
      ena = e; i_vld = v; i_mode = m; i_x = x; rnd = r; i_rdy = rdy;
      #1;
      obs_vld = o_vld; obs_rdy = o_rdy; obs_x = o_x; obs_z = o_z; obs_mode = o_mode;
      exp_vld = (q.size() > 0) && (q[0].age >= 2);
      exp_rdy = e && ((q.size() < 2) || (exp_vld && rdy));
      exp_x = 32'd0; exp_z = 8'd0; exp_mode = 1'b0;
      if (exp_vld) begin
         exp_x = q[0].x; exp_z = q[0].z; exp_mode = q[0].mode;
      end
      acc  = v && exp_rdy;
      xfer = exp_vld && rdy && e;
      @(posedge clk);
      if (e) begin
         if (xfer) void'(q.pop_front());
         foreach (q[k]) q[k].age++;
         if (acc) q.push_back(make_beat(m, x, r));
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; i_vld = 1'b1; i_rdy = 1'b1; i_mode = 1'b0;
      i_x = $urandom; rnd = $urandom;
      v3 = 1'b0; m3 = 1'b0; x3 = '0; r3 = '0;
      v5 = 1'b0; m5 = 1'b0; x5 = '0; r5 = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({o_vld, o_mode, o_x, o_z} !== 42'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {o_vld, o_mode, o_x, o_z});
      end
      checks++;
      if (o_rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdy: got %b expected 0", o_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      step(1'b1, 1'b1, 1'b0, 32'hCAFE0123, 32'h01020304, 1'b1);
      checks++;
      if (obs_rdy !== 1'b1 || obs_vld !== 1'b0) begin
         errors++;
         $display("FAIL first_accept: got rdy=%b vld=%b expected rdy=1 vld=0", obs_rdy, obs_vld);
      end
      repeat (3) begin
         step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
         checks++;
         if (obs_vld !== exp_vld || (exp_vld && obs_z !== exp_z)) begin
            errors++;
            $display("FAIL first_beat: got vld=%b z=%h expected vld=%b z=%h",
                     obs_vld, obs_z, exp_vld, exp_z);
         end
      end
   endtask

   task automatic test_unmask();
      step(1'b1, 1'b1, 1'b0, 32'h12345678, 32'hAA550FF0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      checks++;
      if (obs_vld !== 1'b0) begin
         errors++;
         $display("FAIL unmask_latency1: got vld=%b expected 0", obs_vld);
      end
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      checks++;
      if (obs_vld !== 1'b1 || obs_z !== 8'h08 || obs_mode !== 1'b0) begin
         errors++;
         $display("FAIL unmask_z: got vld=%b z=%h mode=%b expected 1 08 0", obs_vld, obs_z, obs_mode);
      end
      checks++;
      if (obs_x !== 32'hB76E0CDD) begin
         errors++;
         $display("FAIL unmask_x: got %h expected B76E0CDD", obs_x);
      end
   endtask

   task automatic test_refresh();
      step(1'b1, 1'b1, 1'b1, 32'h12345678, 32'hAA550FF0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      checks++;
      if (obs_vld !== 1'b1 || obs_z !== 8'h00 || obs_mode !== 1'b1) begin
         errors++;
         $display("FAIL refresh_z: got vld=%b z=%h mode=%b expected 1 00 1", obs_vld, obs_z, obs_mode);
      end
      checks++;
      if (obs_x !== 32'hB76E0CDD) begin
         errors++;
         $display("FAIL refresh_x: got %h expected B76E0CDD", obs_x);
      end
      checks++;
      if (xor_shares(4, {96'd0, obs_x}) !== 8'h08) begin
         errors++;
         $display("FAIL refresh_xor: got %h expected 08", xor_shares(4, {96'd0, obs_x}));
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int got = 0;
      logic [41:0] prev = '0;
      for (int c = 0; c < 40 && (sent < 10 || q.size() > 0); c++) begin
         step(1'b1, sent < 10, 1'b0, 32'h01010101 * (sent + 1), $urandom,
              !(c >= 8 && c <= 10));
         if (acc) sent++;
         if (xfer) got++;
         checks++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld ||
             (exp_vld && {obs_x, obs_z, obs_mode} !== {exp_x, exp_z, exp_mode})) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got rdy=%b vld=%b x=%h z=%h expected rdy=%b vld=%b x=%h z=%h",
                     c, obs_rdy, obs_vld, obs_x, obs_z, exp_rdy, exp_vld, exp_x, exp_z);
         end
         if (c >= 9 && c <= 11) begin
            checks++;
            if ({obs_vld, obs_mode, obs_x, obs_z} !== prev) begin
               errors++;
               $display("FAIL b2b_frozen%0d: got %h expected %h", c,
                        {obs_vld, obs_mode, obs_x, obs_z}, prev);
            end
         end
         prev = {obs_vld, obs_mode, obs_x, obs_z};
      end
      checks++;
      if (got !== 10) begin
         errors++;
         $display("FAIL b2b_count: got %0d beats expected 10", got);
      end
   endtask

   task automatic test_ena_toggle();
      int sent = 0;
      int got = 0;
      logic [41:0] prev = '0;
      for (int c = 0; c < 40 && (sent < 10 || q.size() > 0); c++) begin
         step(!(c == 5 || c == 6), sent < 10, $urandom_range(0, 1), $urandom, $urandom, 1'b1);
         if (acc) sent++;
         if (xfer) got++;
         checks++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld ||
             (exp_vld && {obs_x, obs_z, obs_mode} !== {exp_x, exp_z, exp_mode})) begin
            errors++;
            $display("FAIL ena_cycle%0d: got rdy=%b vld=%b z=%h expected rdy=%b vld=%b z=%h",
                     c, obs_rdy, obs_vld, obs_z, exp_rdy, exp_vld, exp_z);
         end
         if (c == 6 || c == 7) begin
            checks++;
            if ({obs_vld, obs_mode, obs_x, obs_z} !== prev) begin
               errors++;
               $display("FAIL ena_hold%0d: got %h expected %h", c,
                        {obs_vld, obs_mode, obs_x, obs_z}, prev);
            end
         end
         prev = {obs_vld, obs_mode, obs_x, obs_z};
      end
      checks++;
      if (got !== 10) begin
         errors++;
         $display("FAIL ena_count: got %0d beats expected 10", got);
      end
   endtask

   task automatic test_reset_inflight();
      step(1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b1);
      step(1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b1);
      i_vld = 1'b0;
      #1;
      checks++;
      if (o_vld !== 1'b1) begin
         errors++;
         $display("FAIL inflight_pre: got vld=%b expected 1", o_vld);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (o_vld !== 1'b0 || o_rdy !== 1'b0 || o_x !== 32'd0 || o_z !== 8'd0) begin
         errors++;
         $display("FAIL inflight_reset: got vld=%b rdy=%b x=%h z=%h expected 0 0 0 0",
                  o_vld, o_rdy, o_x, o_z);
      end
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
         checks++;
         if (obs_vld !== 1'b0) begin
            errors++;
            $display("FAIL inflight_stale%0d: got vld=%b expected 0", c, obs_vld);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 7) != 0, c < 390 ? $urandom_range(0, 3) != 0 : 1'b0,
              $urandom_range(0, 1), $urandom, $urandom, c < 390 ? $urandom_range(0, 2) != 0 : 1'b1);
         checks++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld ||
             (exp_vld && {obs_x, obs_z, obs_mode} !== {exp_x, exp_z, exp_mode})) begin
            errors++;
            $display("FAIL rand_cycle%0d: got rdy=%b vld=%b x=%h z=%h m=%b expected rdy=%b vld=%b x=%h z=%h m=%b",
                     c, obs_rdy, obs_vld, obs_x, obs_z, obs_mode,
                     exp_rdy, exp_vld, exp_x, exp_z, exp_mode);
         end
      end
      checks++;
      if (q.size() !== 0) begin
         errors++;
         $display("FAIL rand_drain: got %0d beats left expected 0", q.size());
      end
   endtask

   task automatic test_n3_n5();
      logic [39:0]  qx3[$], qx5[$];
      logic [7:0]   qz3[$], qz5[$];
      logic [63:0]  t;
      logic [127:0] y;
      logic [39:0]  ex;
      logic [7:0]   ez;
      for (int c = 0; c < 1002; c++) begin
         t = {$urandom, $urandom};
         v3 = c < 1000; m3 = t[63]; x3 = t[23:0]; r3 = t[47:32];
         t = {$urandom, $urandom};
         v5 = c < 1000; m5 = t[62]; x5 = t[39:0];
         t = {$urandom, $urandom};
         r5 = t[39:0];
         #1;
         if (c >= 2) begin
            ex = qx3.pop_front(); ez = qz3.pop_front();
            checks++;
            if (vld3 !== 1'b1 || oz3 !== ez || ox3 !== ex[23:0]) begin
               errors++;
               $display("FAIL n3_beat%0d: got vld=%b z=%h x=%h expected vld=1 z=%h x=%h",
                        c - 2, vld3, oz3, ox3, ez, ex[23:0]);
            end
            ex = qx5.pop_front(); ez = qz5.pop_front();
            checks++;
            if (vld5 !== 1'b1 || oz5 !== ez || ox5 !== ex) begin
               errors++;
               $display("FAIL n5_beat%0d: got vld=%b z=%h x=%h expected vld=1 z=%h x=%h",
                        c - 2, vld5, oz5, ox5, ez, ex);
            end
         end else begin
            checks++;
            if (vld3 !== 1'b0 || vld5 !== 1'b0) begin
               errors++;
               $display("FAIL n35_idle%0d: got vld3=%b vld5=%b expected 0 0", c, vld3, vld5);
            end
         end
         if (c < 1000) begin
            checks++;
            if (rdy3 !== 1'b1 || rdy5 !== 1'b1) begin
               errors++;
               $display("FAIL n35_rdy%0d: got rdy3=%b rdy5=%b expected 1 1", c, rdy3, rdy5);
            end
            y = refresh_ref(3, {104'd0, x3}, {240'd0, r3});
            qx3.push_back({16'd0, y[23:0]});
            qz3.push_back(m3 ? 8'h00 : xor_shares(3, {104'd0, x3}));
            y = refresh_ref(5, {88'd0, x5}, {216'd0, r5});
            qx5.push_back(y[39:0]);
            qz5.push_back(m5 ? 8'h00 : xor_shares(5, {88'd0, x5}));
         end
         @(posedge clk);
         @(negedge clk);
      end
      v3 = 1'b0; v5 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_unmask();
      test_refresh();
      test_back_to_back();
      test_ena_toggle();
      test_reset_inflight();
      test_random();
      test_n3_n5();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
